// File: rtl/raster_pkg.sv
// Shared types for the raster tagger: FSM states and the per-pixel tag bundle.
// Tag fields are sized for the widest supported geometry; narrower instances zero-extend.
package raster_pkg;

  localparam int COORD_W_DEF   = 16;
  localparam int FRAME_W_DEF   = 16;
  localparam int TAG_COORD_MAX = 32;
  localparam int TAG_FRAME_MAX = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } raster_state_t;

  typedef struct packed {
    logic [TAG_COORD_MAX-1:0] x;
    logic [TAG_COORD_MAX-1:0] y;
    logic                     sof;
    logic                     eol;
    logic                     eof;
    logic [TAG_FRAME_MAX-1:0] frame;
  } raster_tag_t;

endpackage

// File: rtl/raster_out_reg.sv
// Single-entry valid/ready output register carrying a pixel and its tags.
// The producer only loads when the slot is empty or draining this cycle.
module raster_out_reg
  import raster_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  raster_tag_t       tag_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output raster_tag_t       tag_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  raster_tag_t       tag_q, tag_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      tag_d   = tag_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/raster_tagger.sv
// Tags a valid/ready pixel stream with x/y, line/frame markers and a frame count,
// inserting runtime-sized frames separated by fixed horizontal/vertical blanking.
module raster_tagger
  import raster_pkg::*;
#(
  parameter int PIXEL_SIZE = 24,
  parameter int COORD_W    = COORD_W_DEF,
  parameter int FRAME_W    = FRAME_W_DEF,
  parameter int H_BLANK    = 0,
  parameter int V_BLANK    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [COORD_W-1:0]    cfg_width,
  input  logic [COORD_W-1:0]    cfg_height,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIXEL_SIZE-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PIXEL_SIZE-1:0] m_data,
  output logic [COORD_W-1:0]    x,
  output logic [COORD_W-1:0]    y,
  output logic                  sof,
  output logic                  eol,
  output logic                  eof,
  output logic [FRAME_W-1:0]    frame,
  output logic                  hsync,
  output logic                  vsync
);

  localparam logic [COORD_W-1:0] C_ONE   = COORD_W'(1);
  localparam logic [FRAME_W-1:0] F_ONE   = FRAME_W'(1);
  localparam logic [COORD_W-1:0] HB_LAST = COORD_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [COORD_W-1:0] VB_LAST = COORD_W'((V_BLANK > 0) ? V_BLANK - 1 : 0);

  raster_state_t      state_q, state_d;
  logic [COORD_W-1:0] w_q, w_d, h_q, h_d;
  logic [COORD_W-1:0] x_in_q, x_in_d, y_in_q, y_in_d;
  logic [COORD_W-1:0] blk_q, blk_d;
  logic [FRAME_W-1:0] frm_q, frm_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic               accept, cfg_ok, last_x, last_y;
  raster_tag_t        tag_in, tag_out;
  logic               unused_tag;

  assign cfg_ok = (|cfg_width) && (|cfg_height);
  assign last_x = (x_in_q == w_q - C_ONE);
  assign last_y = (y_in_q == h_q - C_ONE);
  assign accept = s_valid && s_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (en && cfg_ok) state_d = ACTIVE;
      ACTIVE: if (accept && last_x) begin
        if (!last_y) begin
          if (H_BLANK > 0) state_d = HBLANK;
        end else if (V_BLANK > 0) begin
          state_d = VBLANK;
        end else if (!cfg_ok) begin
          state_d = IDLE;
        end
      end
      HBLANK: if (en && blk_q == HB_LAST) state_d = ACTIVE;
      VBLANK: if (en && blk_q == VB_LAST) state_d = cfg_ok ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Backpressure lets a new pixel in whenever the output slot is free or draining.
  always_comb begin
    s_ready = 1'b0;
    if (state_q == ACTIVE) s_ready = en && (!m_valid || m_ready);
  end

  // Geometry is only (re)latched on the edge that starts a frame.
  always_comb begin
    w_d     = w_q;
    h_d     = h_q;
    x_in_d  = x_in_q;
    y_in_d  = y_in_q;
    blk_d   = blk_q;
    frm_d   = frm_q;
    hsync_d = (state_d == HBLANK);
    vsync_d = (state_d == VBLANK);
    case (state_q)
      IDLE: if (en && cfg_ok) begin
        w_d    = cfg_width;
        h_d    = cfg_height;
        x_in_d = '0;
        y_in_d = '0;
      end
      ACTIVE: if (accept) begin
        blk_d = '0;
        if (!last_x) begin
          x_in_d = x_in_q + C_ONE;
        end else begin
          x_in_d = '0;
          if (!last_y) begin
            y_in_d = y_in_q + C_ONE;
          end else begin
            y_in_d = '0;
            frm_d  = frm_q + F_ONE;
            if (state_d == ACTIVE) begin
              w_d = cfg_width;
              h_d = cfg_height;
            end
          end
        end
      end
      HBLANK, VBLANK: if (en) begin
        blk_d = blk_q + C_ONE;
        if (state_q == VBLANK && state_d == ACTIVE) begin
          w_d = cfg_width;
          h_d = cfg_height;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q     <= '0;
      h_q     <= '0;
      x_in_q  <= '0;
      y_in_q  <= '0;
      blk_q   <= '0;
      frm_q   <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      w_q     <= w_d;
      h_q     <= h_d;
      x_in_q  <= x_in_d;
      y_in_q  <= y_in_d;
      blk_q   <= blk_d;
      frm_q   <= frm_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.x     = TAG_COORD_MAX'(x_in_q);
    tag_in.y     = TAG_COORD_MAX'(y_in_q);
    tag_in.sof   = (x_in_q == '0) && (y_in_q == '0);
    tag_in.eol   = last_x;
    tag_in.eof   = last_x && last_y;
    tag_in.frame = TAG_FRAME_MAX'(frm_q);
  end

  raster_out_reg #(.DATA_W(PIXEL_SIZE)) u_out (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (accept),
    .data_i  (s_data),
    .tag_i   (tag_in),
    .ready_i (m_ready),
    .valid_o (m_valid),
    .data_o  (m_data),
    .tag_o   (tag_out)
  );

  assign x     = tag_out.x[COORD_W-1:0];
  assign y     = tag_out.y[COORD_W-1:0];
  assign sof   = tag_out.sof;
  assign eol   = tag_out.eol;
  assign eof   = tag_out.eof;
  assign frame = tag_out.frame[FRAME_W-1:0];
  assign hsync = hsync_q;
  assign vsync = vsync_q;

  // Upper tag bits are always zero for narrow instances.
  assign unused_tag = ^tag_out;

endmodule
